// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bundle of the integer register file with its pending-write scoreboard.
// The master side drives writeback, decode, issue and kill; the slave side returns read data and stall.
interface regfile_scoreboard_if #(
    parameter int XLEN = 32
);
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_write_data;
    logic            wb_regfile_wr_enable;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_rs1_used;
    logic            id_rs2_used;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            issue_wr_enable;
    logic            kill_valid;
    logic [4:0]      kill_rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            stall;

    modport master (
        output wb_rd, wb_write_data, wb_regfile_wr_enable,
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output issue_valid, issue_rd, issue_wr_enable,
        output kill_valid, kill_rd,
        input  rs1_data, rs2_data, stall
    );

    modport slave (
        input  wb_rd, wb_write_data, wb_regfile_wr_enable,
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  issue_valid, issue_rd, issue_wr_enable,
        input  kill_valid, kill_rd,
        output rs1_data, rs2_data, stall
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file x0..x31 with write bypass on both read ports and a per-register
// pending-write counter that stalls decode on RAW hazards or when a counter would overflow.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 2
) (
    input logic                 clk,
    input logic                 rst,
    regfile_scoreboard_if.slave bus
);
    logic [XLEN-1:0]  regs      [32];
    logic [CNT_W-1:0] pend      [32];
    logic [CNT_W-1:0] pend_next [32];
    logic [31:0]      inc;
    logic [31:0]      dec_wb;
    logic [31:0]      dec_k;
    logic [31:0]      underflow;
    logic             busy1;
    logic             busy2;
    logic             full;

    always_comb begin
        inc    = '0;
        dec_wb = '0;
        dec_k  = '0;
        for (int r = 1; r < 32; r++) begin
            inc[r]    = bus.issue_valid && !bus.stall && bus.issue_wr_enable && (bus.issue_rd == 5'(r));
            dec_wb[r] = bus.wb_regfile_wr_enable && (bus.wb_rd == 5'(r));
            dec_k[r]  = bus.kill_valid && (bus.kill_rd == 5'(r));
        end
    end

    // One net update per counter; a decrement that would go below zero clamps at zero.
    always_comb begin
        logic [CNT_W:0] up;
        logic [CNT_W:0] down;
        underflow    = '0;
        pend_next[0] = '0;
        up           = '0;
        down         = '0;
        for (int r = 1; r < 32; r++) begin
            up   = {1'b0, pend[r]} + (CNT_W+1)'(inc[r]);
            down = (CNT_W+1)'(dec_wb[r]) + (CNT_W+1)'(dec_k[r]);
            if (up < down) begin
                underflow[r] = 1'b1;
                pend_next[r] = '0;
            end else begin
                pend_next[r] = CNT_W'(up - down);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                regs[r] <= '0;
                pend[r] <= '0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                pend[r] <= pend_next[r];
            end
            if (bus.wb_regfile_wr_enable && bus.wb_rd != 5'd0) begin
                regs[bus.wb_rd] <= bus.wb_write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (underflow == '0);
        end
    end

    always_comb begin
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        if (bus.id_rs1 != 5'd0) begin
            bus.rs1_data = (bus.wb_regfile_wr_enable && bus.wb_rd == bus.id_rs1)
                           ? bus.wb_write_data : regs[bus.id_rs1];
        end
        if (bus.id_rs2 != 5'd0) begin
            bus.rs2_data = (bus.wb_regfile_wr_enable && bus.wb_rd == bus.id_rs2)
                           ? bus.wb_write_data : regs[bus.id_rs2];
        end
    end

    // A write landing this cycle is bypassed, so its own pending count does not hold decode.
    always_comb begin
        busy1 = bus.id_rs1_used && (bus.id_rs1 != 5'd0)
                && ((pend[bus.id_rs1] - CNT_W'(dec_wb[bus.id_rs1])) != '0);
        busy2 = bus.id_rs2_used && (bus.id_rs2 != 5'd0)
                && ((pend[bus.id_rs2] - CNT_W'(dec_wb[bus.id_rs2])) != '0);
        full  = bus.issue_wr_enable && (bus.issue_rd != 5'd0)
                && (pend[bus.issue_rd] == {CNT_W{1'b1}})
                && !dec_wb[bus.issue_rd] && !dec_k[bus.issue_rd];
        bus.stall = busy1 || busy2 || full;
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed test of regfile_scoreboard: reset, write/read, bypass, RAW stall, counter full,
// simultaneous increment/decrement, double decrement, and reset overriding a writeback.
module tb_regfile_scoreboard;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    regfile_scoreboard_if #(.XLEN(32)) bus ();

    regfile_scoreboard #(.XLEN(32), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.wb_rd                = 5'd0;
        bus.wb_write_data        = 32'd0;
        bus.wb_regfile_wr_enable = 1'b0;
        bus.id_rs1               = 5'd0;
        bus.id_rs2               = 5'd0;
        bus.id_rs1_used          = 1'b0;
        bus.id_rs2_used          = 1'b0;
        bus.issue_valid          = 1'b0;
        bus.issue_rd             = 5'd0;
        bus.issue_wr_enable      = 1'b0;
        bus.kill_valid           = 1'b0;
        bus.kill_rd              = 5'd0;
    endtask

    // Advance one clock; inputs change 1ns after the edge, checks happen 2ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic issue(input logic [4:0] rd);
        bus.issue_valid     = 1'b1;
        bus.issue_rd        = rd;
        bus.issue_wr_enable = 1'b1;
    endtask

    task automatic writeback(input logic [4:0] rd, input logic [31:0] data);
        bus.wb_regfile_wr_enable = 1'b1;
        bus.wb_rd                = rd;
        bus.wb_write_data        = data;
    endtask

    task automatic apply_stimulus();
        // Reset and scan all registers on both ports
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int r = 0; r < 32; r++) begin
            bus.id_rs1      = 5'(r);
            bus.id_rs2      = 5'(31 - r);
            bus.id_rs1_used = 1'b1;
            bus.id_rs2_used = 1'b1;
            settle();
            check_output($sformatf("reset_rs1_x%0d", r), bus.rs1_data, 32'd0);
            check_output($sformatf("reset_rs2_x%0d", 31 - r), bus.rs2_data, 32'd0);
            check_output($sformatf("reset_stall_%0d", r), 32'(bus.stall), 32'd0);
        end
        idle();
        tick();

        // Write x5 then read it back; x0 ignores writes
        issue(5'd5);
        settle();
        check_output("issue_x5_stall", 32'(bus.stall), 32'd0);
        tick();
        idle();
        writeback(5'd5, 32'hDEADBEEF);
        tick();
        idle();
        bus.id_rs1 = 5'd5;
        bus.id_rs1_used = 1'b1;
        settle();
        check_output("read_x5", bus.rs1_data, 32'hDEADBEEF);
        check_output("read_x5_stall", 32'(bus.stall), 32'd0);
        writeback(5'd0, 32'h1234);
        bus.id_rs2 = 5'd0;
        bus.id_rs2_used = 1'b1;
        settle();
        check_output("x0_bypass", bus.rs2_data, 32'd0);
        tick();
        idle();
        bus.id_rs1 = 5'd0;
        settle();
        check_output("x0_after_write", bus.rs1_data, 32'd0);

        // Same-cycle bypass on both ports
        issue(5'd7);
        tick();
        idle();
        writeback(5'd7, 32'hA5A5A5A5);
        bus.id_rs1 = 5'd7;
        bus.id_rs2 = 5'd7;
        bus.id_rs1_used = 1'b1;
        bus.id_rs2_used = 1'b1;
        settle();
        check_output("bypass_rs1", bus.rs1_data, 32'hA5A5A5A5);
        check_output("bypass_rs2", bus.rs2_data, 32'hA5A5A5A5);
        check_output("bypass_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.wb_regfile_wr_enable = 1'b0;
        bus.wb_write_data = 32'd0;
        settle();
        check_output("stored_x7", bus.rs1_data, 32'hA5A5A5A5);

        // RAW stall on x3 until its writeback lands
        idle();
        issue(5'd3);
        tick();
        idle();
        bus.id_rs1 = 5'd3;
        bus.id_rs1_used = 1'b1;
        settle();
        check_output("raw_stall_c1", 32'(bus.stall), 32'd1);
        tick();
        settle();
        check_output("raw_stall_c2", 32'(bus.stall), 32'd1);
        writeback(5'd3, 32'h11);
        settle();
        check_output("raw_release_stall", 32'(bus.stall), 32'd0);
        check_output("raw_release_data", bus.rs1_data, 32'h11);
        tick();
        idle();
        issue(5'd3);
        tick();
        idle();
        bus.id_rs1 = 5'd3;
        settle();
        check_output("unused_rs1_no_stall", 32'(bus.stall), 32'd0);
        // Issue attempted while stalled must not increment
        bus.id_rs1_used = 1'b1;
        issue(5'd3);
        settle();
        check_output("used_rs1_stall", 32'(bus.stall), 32'd1);
        tick();
        bus.issue_valid = 1'b0;
        writeback(5'd3, 32'h22);
        tick();
        idle();
        bus.id_rs1 = 5'd3;
        bus.id_rs1_used = 1'b1;
        settle();
        check_output("stalled_issue_ignored", 32'(bus.stall), 32'd0);
        check_output("x3_second_write", bus.rs1_data, 32'h22);

        // Counter full, inc+dec cancel, kill+wb double decrement on x9
        idle();
        for (int i = 0; i < 3; i++) begin
            issue(5'd9);
            settle();
            check_output($sformatf("x9_issue_%0d", i), 32'(bus.stall), 32'd0);
            tick();
        end
        settle();
        check_output("x9_full", 32'(bus.stall), 32'd1);
        tick();
        writeback(5'd9, 32'h91);
        settle();
        check_output("x9_issue_wb_not_full", 32'(bus.stall), 32'd0);
        tick();
        idle();
        issue(5'd9);
        settle();
        check_output("x9_still_full", 32'(bus.stall), 32'd1);
        idle();
        writeback(5'd9, 32'h92);
        bus.kill_valid = 1'b1;
        bus.kill_rd = 5'd9;
        tick();
        idle();
        bus.id_rs1 = 5'd9;
        bus.id_rs1_used = 1'b1;
        settle();
        check_output("x9_one_left", 32'(bus.stall), 32'd1);
        check_output("x9_data", bus.rs1_data, 32'h92);
        idle();
        issue(5'd9);
        settle();
        check_output("x9_refill_1", 32'(bus.stall), 32'd0);
        tick();
        settle();
        check_output("x9_refill_2", 32'(bus.stall), 32'd0);
        tick();
        settle();
        check_output("x9_refull", 32'(bus.stall), 32'd1);
        idle();
        for (int i = 0; i < 3; i++) begin
            writeback(5'd9, 32'h99);
            tick();
        end
        idle();
        bus.id_rs1 = 5'd9;
        bus.id_rs1_used = 1'b1;
        settle();
        check_output("x9_drained", 32'(bus.stall), 32'd0);

        // Reset overrides a same-cycle writeback and clears pending counts
        idle();
        issue(5'd4);
        tick();
        tick();
        idle();
        bus.id_rs1 = 5'd4;
        bus.id_rs1_used = 1'b1;
        settle();
        check_output("x4_pending", 32'(bus.stall), 32'd1);
        writeback(5'd4, 32'h44);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        bus.id_rs1 = 5'd4;
        bus.id_rs1_used = 1'b1;
        bus.id_rs2 = 5'd5;
        bus.id_rs2_used = 1'b1;
        settle();
        check_output("rst_x4_data", bus.rs1_data, 32'd0);
        check_output("rst_x5_data", bus.rs2_data, 32'd0);
        check_output("rst_stall", 32'(bus.stall), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle();
        apply_stimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
